// File: rtl/rv32im_icache_assoc.sv
// ---------------------------------------------------------------------------
// rv32im_icache_assoc
//
// Fully associative instruction cache for the rv32im fetch stage. Lines are
// replaced round-robin. fence.i invalidates the whole cache through flush_i.
// Misaligned fetches and bus errors raise a one-cycle fault pulse. Misses fill
// a whole line over the shared Wishbone bus after the arbiter grants the bus.
//
// Optional feature: define ICACHE_PERF_COUNTERS_EN to add the hit_count_o and
// miss_count_o ports. Each counter counts hit/miss decisions taken in IDLE,
// wraps at 2**XLEN and is cleared only by reset_i.
//
// Ports
//   clk_i, reset_i     clock, synchronous active-high reset
//   req_i, addr_i      fetch request and byte address (held while busy_o)
//   flush_i            invalidate all lines
//   instr_o, valid_o   instruction word, valid one cycle after a hit
//   busy_o             line fill in progress
//   fault_o            one-cycle pulse: misaligned fetch or bus error
//   ctrl_req_o         bus arbitration request; ctrl_grant_i grants the bus
//   master_dat_i       Wishbone read data; ack_i/err_i terminate a beat
//   adr_o              Wishbone word address; cyc_o, stb_o, sel_o (all lanes)
// ---------------------------------------------------------------------------
module rv32im_icache_assoc #(
   parameter int XLEN             = 32,
   parameter int CACHE_LEN        = 7,
   parameter int LINE_LEN         = 4,
   parameter int UNUSED_ADDR_BITS = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            req_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o,
   output logic            busy_o,
   output logic            fault_o,
   output logic            ctrl_req_o,
   input  logic            ctrl_grant_i,
   input  logic [XLEN-1:0] master_dat_i,
   input  logic            ack_i,
   input  logic            err_i,
   output logic [XLEN-3:0] adr_o,
   output logic            cyc_o,
   output logic            stb_o,
`ifdef ICACHE_PERF_COUNTERS_EN
   output logic [XLEN-1:0] hit_count_o,
   output logic [XLEN-1:0] miss_count_o,
`endif
   output logic [3:0]      sel_o
);

   localparam int LINE_IDX_W = CACHE_LEN - LINE_LEN;
   localparam int LINE_COUNT = 1 << LINE_IDX_W;
   localparam int WORDS      = 1 << CACHE_LEN;
   localparam int TAG_W      = XLEN - UNUSED_ADDR_BITS - LINE_LEN - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARB,
      S_FILL,
      S_DONE
   } state_t;

   state_t state_reg, state_next;

   // Line bookkeeping
   logic [LINE_COUNT-1:0] valid_bits_reg;
   logic [TAG_W-1:0]      tag_mem [LINE_COUNT];
   logic [LINE_IDX_W-1:0] victim_reg;
   logic [TAG_W-1:0]      fill_tag_reg;
   logic [LINE_LEN-1:0]   idx_reg;
   logic                  flush_pend_reg;
   logic                  fault_reg;
   logic                  valid_out_reg;

   // Data store: one write port for fills, one registered read port for hits
   logic [XLEN-1:0]       data_mem [WORDS];
   logic [XLEN-1:0]       rd_data_reg;
   logic [CACHE_LEN-1:0]  rd_addr;
   logic [CACHE_LEN-1:0]  wr_addr;

   // Lookup
   logic [TAG_W-1:0]      req_tag;
   logic [LINE_COUNT-1:0] match;
   logic                  hit_any;
   logic [LINE_IDX_W-1:0] hit_idx;

   // Decoded events
   logic in_idle;
   logic req_misaligned;
   logic req_aligned;
   logic do_hit;
   logic do_miss;
   logic fill_start;
   logic fill_ack;
   logic fill_err;
   logic fill_last;
   logic flush_now;

   // The top address bits never take part in a tag; they are dropped here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_i[XLEN-1 -: UNUSED_ADDR_BITS];

   assign req_tag = addr_i[XLEN-1-UNUSED_ADDR_BITS : LINE_LEN+2];

   generate
      for (genvar gi = 0; gi < LINE_COUNT; gi++) begin : g_match
         assign match[gi] = valid_bits_reg[gi] && (tag_mem[gi] == req_tag);
      end
   endgenerate

   assign hit_any = |match;

   // Scan from the top so that the lowest matching line wins.
   always_comb begin
      hit_idx = '0;
      for (int i = LINE_COUNT - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_idx = LINE_IDX_W'(i);
         end
      end
   end

   assign in_idle        = (state_reg == S_IDLE);
   assign req_misaligned = in_idle && req_i && (addr_i[1:0] != 2'b00);
   assign req_aligned    = in_idle && req_i && (addr_i[1:0] == 2'b00);
   // A flush in the same cycle as a lookup wipes the line that would have hit.
   assign do_hit         = req_aligned && hit_any && !flush_i;
   assign do_miss        = req_aligned && (!hit_any || flush_i);
   assign fill_start     = (state_reg == S_ARB) && ctrl_grant_i;
   // err_i takes precedence over a simultaneous ack_i.
   assign fill_err       = (state_reg == S_FILL) && err_i;
   assign fill_ack       = (state_reg == S_FILL) && ack_i && !err_i;
   assign fill_last      = fill_ack && (&idx_reg);
   // A flush seen during or at the end of a fill takes effect when it ends.
   assign flush_now      = flush_pend_reg || flush_i;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy_o     = 1'b0;
      ctrl_req_o = 1'b0;
      cyc_o      = 1'b0;
      stb_o      = 1'b0;
      adr_o      = '0;
      unique case (state_reg)
         S_IDLE: begin
            if (do_miss) begin
               state_next = S_ARB;
            end
         end
         S_ARB: begin
            busy_o     = 1'b1;
            ctrl_req_o = 1'b1;
            if (ctrl_grant_i) begin
               state_next = S_FILL;
            end
         end
         S_FILL: begin
            busy_o     = 1'b1;
            ctrl_req_o = 1'b1;
            cyc_o      = 1'b1;
            stb_o      = 1'b1;
            adr_o      = {{UNUSED_ADDR_BITS{1'b0}}, fill_tag_reg, idx_reg};
            if (fill_err) begin
               state_next = S_IDLE;
            end else if (fill_last) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            // busy_o stays high here so the held request is looked up only
            // once the tag is written, giving valid_o one cycle after busy_o falls.
            busy_o     = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Line state, victim pointer, fill index, pulses
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_bits_reg <= '0;
         victim_reg     <= '0;
         fill_tag_reg   <= '0;
         idx_reg        <= '0;
         flush_pend_reg <= 1'b0;
         fault_reg      <= 1'b0;
         valid_out_reg  <= 1'b0;
      end else begin
         fault_reg     <= req_misaligned || fill_err;
         valid_out_reg <= do_hit;

         if (do_miss) begin
            fill_tag_reg <= req_tag;
         end

         // The victim line goes invalid before its first word is overwritten.
         if (fill_start) begin
            idx_reg                    <= '0;
            valid_bits_reg[victim_reg] <= 1'b0;
         end

         if (fill_ack) begin
            idx_reg <= idx_reg + LINE_LEN'(1);
         end

         if (in_idle && flush_i) begin
            valid_bits_reg <= '0;
            victim_reg     <= '0;
            flush_pend_reg <= 1'b0;
         end else if (((state_reg == S_ARB) || (state_reg == S_FILL)) && flush_i) begin
            flush_pend_reg <= 1'b1;
         end

         if (fill_err) begin
            if (flush_now) begin
               valid_bits_reg <= '0;
               victim_reg     <= '0;
            end
            flush_pend_reg <= 1'b0;
         end

         if (state_reg == S_DONE) begin
            if (flush_now) begin
               valid_bits_reg <= '0;
               victim_reg     <= '0;
            end else begin
               valid_bits_reg[victim_reg] <= 1'b1;
               victim_reg                 <= victim_reg + LINE_IDX_W'(1);
            end
            flush_pend_reg <= 1'b0;
         end
      end
   end

   // Tags need no reset: a tag is only trusted when its valid bit is set.
   always_ff @(posedge clk_i) begin
      if ((state_reg == S_DONE) && !flush_now) begin
         tag_mem[victim_reg] <= fill_tag_reg;
      end
   end

   // ------------------------------------------------------------------
   // Data store
   // ------------------------------------------------------------------
   assign wr_addr = {victim_reg, idx_reg};
   assign rd_addr = {hit_idx, addr_i[LINE_LEN+1:2]};

   always_ff @(posedge clk_i) begin
      if (fill_ack) begin
         data_mem[wr_addr] <= master_dat_i;
      end
      rd_data_reg <= data_mem[rd_addr];
   end

   assign instr_o = rd_data_reg;
   assign valid_o = valid_out_reg;
   assign fault_o = fault_reg;
   assign sel_o   = 4'b1111;

`ifdef ICACHE_PERF_COUNTERS_EN
   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   logic [XLEN-1:0] hit_count_reg;
   logic [XLEN-1:0] miss_count_reg;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else begin
         if (do_hit) begin
            hit_count_reg <= hit_count_reg + XLEN'(1);
         end
         if (do_miss) begin
            miss_count_reg <= miss_count_reg + XLEN'(1);
         end
      end
   end

   assign hit_count_o  = hit_count_reg;
   assign miss_count_o = miss_count_reg;
`endif

endmodule

// File: tb/tb_rv32im_icache_assoc.sv
// ---------------------------------------------------------------------------
// tb_rv32im_icache_assoc
//
// Directed and randomized fetch sequences against a 4-line x 4-word cache.
// The expected hit/miss outcome comes from a small model of the cache contents
// (list of resident line tags plus a round-robin pointer); instruction words
// come from a random backing memory that also feeds the bus.
// ---------------------------------------------------------------------------
module tb_rv32im_icache_assoc;

   localparam int XLEN = 32;

   logic            clk_i = 1'b0;
   logic            reset_i = 1'b1;
   logic            req_i = 1'b0;
   logic [XLEN-1:0] addr_i = '0;
   logic            flush_i = 1'b0;
   logic [XLEN-1:0] instr_o;
   logic            valid_o;
   logic            busy_o;
   logic            fault_o;
   logic            ctrl_req_o;
   logic            ctrl_grant_i = 1'b0;
   logic [XLEN-1:0] master_dat_i = '0;
   logic            ack_i = 1'b0;
   logic            err_i = 1'b0;
   logic [XLEN-3:0] adr_o;
   logic            cyc_o;
   logic            stb_o;
   logic [3:0]      sel_o;
`ifdef ICACHE_PERF_COUNTERS_EN
   logic [XLEN-1:0] hit_count_o;
   logic [XLEN-1:0] miss_count_o;
`endif

   rv32im_icache_assoc #(
      .XLEN             (XLEN),
      .CACHE_LEN        (4),
      .LINE_LEN         (2),
      .UNUSED_ADDR_BITS (8)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_i        (req_i),
      .addr_i       (addr_i),
      .flush_i      (flush_i),
      .instr_o      (instr_o),
      .valid_o      (valid_o),
      .busy_o       (busy_o),
      .fault_o      (fault_o),
      .ctrl_req_o   (ctrl_req_o),
      .ctrl_grant_i (ctrl_grant_i),
      .master_dat_i (master_dat_i),
      .ack_i        (ack_i),
      .err_i        (err_i),
      .adr_o        (adr_o),
      .cyc_o        (cyc_o),
      .stb_o        (stb_o),
`ifdef ICACHE_PERF_COUNTERS_EN
      .hit_count_o  (hit_count_o),
      .miss_count_o (miss_count_o),
`endif
      .sel_o        (sel_o)
   );

   always #5 clk_i = ~clk_i;

   int n_assert = 0;
   int n_fail   = 0;

   // Backing memory, indexed by word address bits [9:0]
   logic [31:0] mem_arr [1024];

   // Cache model: which line tags are resident, and where the next fill goes
   logic [19:0] model_tag [4];
   bit          model_val [4];
   int          model_ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_find(input logic [31:0] a);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) begin
         if (r < 0 && model_val[i] && model_tag[i] == a[23:4]) r = i;
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) model_val[i] = 1'b0;
      model_ptr = 0;
   endtask

   // One fetch. err_beat: beat index to terminate with err_i (-1: none).
   // flush_beat: beat index carrying flush_i (-1: none, -2: with the request).
   task automatic fetch(input logic [31:0] a, input int gdel, input int err_beat,
                        input int flush_beat, input bit gaps);
      int          li;
      logic [29:0] base;
      bit          flushed;
      flushed = 1'b0;
      if (flush_beat == -2) model_clear();
      li = model_find(a);
      req_i   = 1'b1;
      addr_i  = a;
      flush_i = (flush_beat == -2);
      @(negedge clk_i);
      flush_i = 1'b0;
      if (li >= 0) begin
         chk("hit_valid", {31'b0, valid_o}, 32'd1);
         chk("hit_instr", instr_o, mem_arr[a[11:2]]);
         chk("hit_nobus", {30'b0, ctrl_req_o, cyc_o}, 32'd0);
         req_i = 1'b0;
         $display("fetch %h hit  instr %h", a, instr_o);
         return;
      end
      chk("miss_busy", {31'b0, busy_o}, 32'd1);
      chk("miss_valid", {31'b0, valid_o}, 32'd0);
      chk("arb_req", {31'b0, ctrl_req_o}, 32'd1);
      for (int i = 0; i < gdel; i++) begin
         @(negedge clk_i);
         chk("arb_nocyc", {31'b0, cyc_o}, 32'd0);
      end
      ctrl_grant_i = 1'b1;
      @(negedge clk_i);
      ctrl_grant_i = 1'b0;
      model_val[model_ptr] = 1'b0;
      chk("fill_cyc", {29'b0, cyc_o, stb_o, ctrl_req_o}, 32'd7);
      base = {8'h00, a[23:4], 2'b00};
      for (int b = 0; b < 4; b++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            @(negedge clk_i);
            chk("gap_adr", {2'b0, adr_o}, {2'b0, base} + b);
         end
         chk("fill_adr", {2'b0, adr_o}, {2'b0, base} + b);
         master_dat_i = mem_arr[{a[11:4], 2'(b)}];
         if (b == err_beat) begin
            ack_i = 1'b1;
            err_i = 1'b1;
            @(negedge clk_i);
            ack_i = 1'b0;
            err_i = 1'b0;
            req_i = 1'b0;
            chk("err_fault", {31'b0, fault_o}, 32'd1);
            chk("err_bus", {28'b0, cyc_o, stb_o, ctrl_req_o, busy_o}, 32'd0);
            if (flushed) model_clear();
            @(negedge clk_i);
            chk("err_pulse", {31'b0, fault_o}, 32'd0);
            $display("fetch %h miss bus error at beat %0d", a, b);
            return;
         end
         ack_i   = 1'b1;
         flush_i = (b == flush_beat);
         if (b == flush_beat) flushed = 1'b1;
         @(negedge clk_i);
         ack_i   = 1'b0;
         flush_i = 1'b0;
      end
      chk("done_bus", {29'b0, cyc_o, stb_o, ctrl_req_o}, 32'd0);
      chk("done_busy", {31'b0, busy_o}, 32'd1);
      if (flushed) begin
         model_clear();
      end else begin
         model_tag[model_ptr] = a[23:4];
         model_val[model_ptr] = 1'b1;
         model_ptr = (model_ptr + 1) % 4;
      end
      @(negedge clk_i);
      chk("busy_fall", {31'b0, busy_o}, 32'd0);
      if (flushed) req_i = 1'b0;
      @(negedge clk_i);
      if (flushed) begin
         chk("flush_novalid", {31'b0, valid_o}, 32'd0);
      end else begin
         chk("fill_valid", {31'b0, valid_o}, 32'd1);
         chk("fill_instr", instr_o, mem_arr[a[11:2]]);
      end
      req_i = 1'b0;
      $display("fetch %h miss filled%s instr %h", a, flushed ? " (flushed)" : "", instr_o);
   endtask

   task automatic misaligned(input logic [31:0] a);
      req_i  = 1'b1;
      addr_i = a;
      @(negedge clk_i);
      req_i = 1'b0;
      chk("mis_fault", {31'b0, fault_o}, 32'd1);
      chk("mis_noreq", {30'b0, ctrl_req_o, valid_o}, 32'd0);
      @(negedge clk_i);
      chk("mis_pulse", {31'b0, fault_o}, 32'd0);
      chk("mis_noreq2", {30'b0, ctrl_req_o, busy_o}, 32'd0);
      $display("fetch %h misaligned", a);
   endtask

   task automatic flush_idle();
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      model_clear();
      $display("flush");
   endtask

   initial begin
      logic [31:0] ra;
      int          eb;
      for (int i = 0; i < 1024; i++) mem_arr[i] = $urandom;
      model_clear();

      // Reset state
      reset_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_outs", {26'b0, valid_o, busy_o, fault_o, ctrl_req_o, cyc_o, stb_o}, 32'd0);
      chk("rst_adr", {2'b0, adr_o}, 32'd0);
      chk("rst_sel", {28'b0, sel_o}, 32'hF);
      reset_i = 1'b0;
      @(negedge clk_i);
      $display("reset released");

      // Cold fill, then hits (upper address bits are ignored)
      fetch(32'h0000_0100, 2, -1, -1, 1'b0);
      fetch(32'h0000_0104, 0, -1, -1, 1'b0);
      fetch(32'hFF00_0108, 0, -1, -1, 1'b0);

      misaligned(32'h0000_0102);

      // Round-robin eviction
      flush_idle();
      fetch(32'h0000_0100, 0, -1, -1, 1'b0);
      fetch(32'h0000_0000, 1, -1, -1, 1'b0);
      fetch(32'h0000_0010, 0, -1, -1, 1'b0);
      fetch(32'h0000_0020, 0, -1, -1, 1'b0);
      fetch(32'h0000_0030, 0, -1, -1, 1'b0);
      fetch(32'h0000_0040, 0, -1, -1, 1'b0);
      fetch(32'h0000_0014, 0, -1, -1, 1'b0);
      fetch(32'h0000_0000, 0, -1, -1, 1'b0);
      fetch(32'h0000_0048, 0, -1, -1, 1'b0);

      // Bus error on the third beat
      fetch(32'h0000_0200, 1, 2, -1, 1'b0);
      fetch(32'h0000_0200, 0, -1, -1, 1'b0);
      fetch(32'h0000_0204, 0, -1, -1, 1'b0);

      // Flush mid-fill, then flush with a same-cycle request
      fetch(32'h0000_0300, 0, -1, 1, 1'b0);
      fetch(32'h0000_0300, 0, -1, -1, 1'b0);
      fetch(32'h0000_0308, 0, -1, -2, 1'b0);
      fetch(32'h0000_030C, 0, -1, -1, 1'b0);

      // Randomized fetches over eight candidate lines
      for (int n = 0; n < 60; n++) begin
         ra = 32'h800 + ($urandom_range(0, 7) << 4) + ($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 5) == 0) ra[31:24] = 8'($urandom);
         eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
         fetch(ra, int'($urandom_range(0, 3)), eb, -1, 1'b1);
      end

      // Reset during a fill
      fetch(32'h0000_0500, 0, -1, -1, 1'b0);
      fetch(32'h0000_0504, 0, -1, -1, 1'b0);
      req_i  = 1'b1;
      addr_i = 32'h0000_0600;
      @(negedge clk_i);
      ctrl_grant_i = 1'b1;
      @(negedge clk_i);
      ctrl_grant_i = 1'b0;
      ack_i        = 1'b1;
      master_dat_i = mem_arr[10'h180];
      @(negedge clk_i);
      ack_i   = 1'b0;
      reset_i = 1'b1;
      @(negedge clk_i);
      chk("rst_fill_bus", {28'b0, cyc_o, stb_o, ctrl_req_o, busy_o}, 32'd0);
      reset_i = 1'b0;
      req_i   = 1'b0;
      model_clear();
      @(negedge clk_i);
      $display("reset during fill");
      fetch(32'h0000_0500, 0, -1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
